// File: rtl/bcd_seq_ctrl.sv
// Sequencing controller for a cascaded DIGITS-wide BCD counter: run/pause/clear/load FSM, tick prescaler, carry/borrow enables, target detect.
// Latency: commands and ticks take effect on the next clk edge; count_bcd, digit_en, done and state are all registered outputs.
// Backpressure: cmd_ready is 1 except for the single cycle after an accepted command; unaccepted cmd_op/cmd_data are ignored.
//
// Ports:
//   clk, rst_asyn          rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_op 00 start, 01 stop, 10 clear, 11 load
//   cmd_data               BCD load value (load only)
//   dir                    0 up, 1 down, sampled on each tick
//   target                 BCD terminal value, compared on ticks only
//   count_bcd              current count, one BCD nibble per digit
//   digit_en               one-cycle pulse per digit changed by a tick
//   state                  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   done                   one-cycle pulse when a tick lands on target
//   err                    sticky: bad load data, or load attempted in RUN
module bcd_seq_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                  clk,
  input  logic                  rst_asyn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [4*DIGITS-1:0]   cmd_data,
  input  logic                  dir,
  input  logic [4*DIGITS-1:0]   target,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [DIGITS-1:0]     digit_en,
  output logic [1:0]            state,
  output logic                  done,
  output logic                  err
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t                state_q, state_n;
  logic [PW-1:0]         psc_q, psc_n;
  logic [4*DIGITS-1:0]   count_q, count_n;
  logic [DIGITS-1:0]     en_q, en_n;
  logic                  done_q, done_n;
  logic                  err_q, err_n;
  logic                  ready_q;

  logic                  accept;
  logic                  tick;
  logic                  match;
  logic                  load_ok;
  logic [4*DIGITS-1:0]   stepped;
  logic [DIGITS-1:0]     changed;
  logic                  ripple;
  logic [3:0]            nib;

  assign accept = cmd_valid && ready_q;
  assign tick   = (state_q == S_RUN) && (psc_q == PLAST);

  // Single-step BCD increment/decrement. A digit moves only while every
  // lower digit sits at its wrap point (9 going up, 0 going down); the
  // running 'ripple' term carries that condition upward.
  always_comb begin
    stepped = count_q;
    changed = '0;
    ripple  = 1'b1;
    nib     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      nib        = count_q[4*i +: 4];
      changed[i] = ripple;
      if (ripple) begin
        if (dir) stepped[4*i +: 4] = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
        else     stepped[4*i +: 4] = (nib == 4'd9) ? 4'd0 : nib + 4'd1;
      end
      ripple = ripple && (dir ? (nib == 4'd0) : (nib == 4'd9));
    end
  end

  assign match = (stepped == target);

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cmd_data[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // Next-state / datapath. The tick is applied first, then an accepted
  // command overrides it: clear beats a target match, and a match beats stop.
  always_comb begin
    state_n = state_q;
    psc_n   = psc_q;
    count_n = count_q;
    en_n    = '0;
    done_n  = 1'b0;
    err_n   = err_q;

    if (tick) begin
      count_n = stepped;
      en_n    = changed;
      psc_n   = '0;
      if (match) begin
        state_n = S_DONE;
        done_n  = 1'b1;
      end
    end else if (state_q == S_RUN) begin
      psc_n = psc_q + PW'(1);
    end

    if (accept) begin
      case (cmd_op)
        OP_START: begin
          // PAUSE resumes with the held prescaler phase; IDLE/DONE restart it.
          if (state_q == S_PAUSE) begin
            state_n = S_RUN;
          end else if (state_q != S_RUN) begin
            state_n = S_RUN;
            psc_n   = '0;
          end
        end
        OP_STOP: begin
          if (state_q == S_RUN && !(tick && match)) state_n = S_PAUSE;
        end
        OP_CLEAR: begin
          state_n = S_IDLE;
          count_n = '0;
          psc_n   = '0;
          err_n   = 1'b0;
          done_n  = 1'b0;
        end
        default: begin // OP_LOAD
          if (state_q == S_RUN) err_n = 1'b1;
          else if (load_ok)     count_n = cmd_data;
          else                  err_n = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_asyn) begin
    if (!rst_asyn) begin
      state_q <= S_IDLE;
      psc_q   <= '0;
      count_q <= '0;
      en_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_n;
      psc_q   <= psc_n;
      count_q <= count_n;
      en_q    <= en_n;
      done_q  <= done_n;
      err_q   <= err_n;
      ready_q <= !accept;
    end
  end

  assign cmd_ready = ready_q;
  assign count_bcd = count_q;
  assign digit_en  = en_q;
  assign state     = state_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed bench for bcd_seq_ctrl with DIGITS=4, PRESCALE=2.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
// Each scenario task checks its own hand-computed values.
module tb_bcd_seq_ctrl;

  logic        clk;
  logic        rst_asyn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        dir;
  logic [15:0] target;
  logic [15:0] count_bcd;
  logic [3:0]  digit_en;
  logic [1:0]  state;
  logic        done;
  logic        err;

  int n_checks;
  int n_fail;

  bcd_seq_ctrl #(.DIGITS(4), .PRESCALE(2)) dut (
    .clk       (clk),
    .rst_asyn  (rst_asyn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .dir       (dir),
    .target    (target),
    .count_bcd (count_bcd),
    .digit_en  (digit_en),
    .state     (state),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a command and hold it until the edge that accepts it; returns 1ns after that edge.
  task automatic send_cmd(input logic [1:0] op, input logic [15:0] data);
    int n;
    n = 0;
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 8) begin
      step(1);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    step(1);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 16'h0000;
  endtask

  task automatic test_reset;
    rst_asyn = 1'b0;
    #12;
    n_checks++;
    if (state !== 2'b00 || count_bcd !== 16'h0000 || digit_en !== 4'b0000 ||
        done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: state=%b count=%h en=%b done=%b err=%b ready=%b required 00 0000 0000 0 0 1",
               state, count_bcd, digit_en, done, err, cmd_ready);
    end
    rst_asyn = 1'b1;
    step(1);
  endtask

  task automatic test_count_up;
    logic [15:0] exp;
    logic [3:0]  exp_en;
    target = 16'h0012;
    dir    = 1'b0;
    send_cmd(2'b00, 16'h0000);
    n_checks++;
    if (state !== 2'b01 || count_bcd !== 16'h0000) begin
      n_fail++;
      $display("FAIL up_start: state=%b count=%h required 01 0000", state, count_bcd);
    end
    step(1);
    n_checks++;
    if (count_bcd !== 16'h0000 || digit_en !== 4'b0000) begin
      n_fail++;
      $display("FAIL up_no_tick: count=%h en=%b required 0000 0000", count_bcd, digit_en);
    end
    step(1);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) step(2);
      exp    = 16'(((k / 10) << 4) | (k % 10));
      exp_en = (k == 10) ? 4'b0011 : 4'b0001;
      n_checks++;
      if (count_bcd !== exp || digit_en !== exp_en) begin
        n_fail++;
        $display("FAIL up_tick_%0d: count=%h en=%b required %h %b", k, count_bcd, digit_en, exp, exp_en);
      end
      n_checks++;
      if (state !== ((k == 12) ? 2'b11 : 2'b01) || done !== (k == 12)) begin
        n_fail++;
        $display("FAIL up_state_%0d: state=%b done=%b", k, state, done);
      end
    end
    step(1);
    n_checks++;
    if (done !== 1'b0 || state !== 2'b11 || count_bcd !== 16'h0012) begin
      n_fail++;
      $display("FAIL up_done_pulse: done=%b state=%b count=%h required 0 11 0012", done, state, count_bcd);
    end
  endtask

  task automatic test_wrap_up;
    logic [15:0] exp_c [5];
    logic [3:0]  exp_e [5];
    exp_c = '{16'h9999, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
    exp_e = '{4'b0001, 4'b1111, 4'b0001, 4'b0001, 4'b0001};
    send_cmd(2'b10, 16'h0000);
    n_checks++;
    if (state !== 2'b00 || count_bcd !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_clear: state=%b count=%h required 00 0000", state, count_bcd);
    end
    send_cmd(2'b11, 16'h9998);
    n_checks++;
    if (count_bcd !== 16'h9998 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_load: count=%h err=%b required 9998 0", count_bcd, err);
    end
    target = 16'h0003;
    dir    = 1'b0;
    send_cmd(2'b00, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      step(2);
      n_checks++;
      if (count_bcd !== exp_c[k] || digit_en !== exp_e[k] || done !== (k == 4)) begin
        n_fail++;
        $display("FAIL wrap_up_%0d: count=%h en=%b done=%b required %h %b %b",
                 k, count_bcd, digit_en, done, exp_c[k], exp_e[k], (k == 4));
      end
    end
    n_checks++;
    if (state !== 2'b11) begin
      n_fail++;
      $display("FAIL wrap_up_done_state: state=%b required 11", state);
    end
  endtask

  task automatic test_wrap_down_pause;
    send_cmd(2'b11, 16'h0001);
    n_checks++;
    if (count_bcd !== 16'h0001 || state !== 2'b11) begin
      n_fail++;
      $display("FAIL down_load_in_done: count=%h state=%b required 0001 11", count_bcd, state);
    end
    dir    = 1'b1;
    target = 16'h5000;
    send_cmd(2'b00, 16'h0000);
    step(2);
    n_checks++;
    if (count_bcd !== 16'h0000 || digit_en !== 4'b0001) begin
      n_fail++;
      $display("FAIL down_tick1: count=%h en=%b required 0000 0001", count_bcd, digit_en);
    end
    step(2);
    n_checks++;
    if (count_bcd !== 16'h9999 || digit_en !== 4'b1111 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL down_wrap: count=%h en=%b done=%b required 9999 1111 0", count_bcd, digit_en, done);
    end
    // Stop lands mid-period, leaving the prescaler one cycle from a tick.
    send_cmd(2'b01, 16'h0000);
    n_checks++;
    if (state !== 2'b10 || count_bcd !== 16'h9999) begin
      n_fail++;
      $display("FAIL pause_enter: state=%b count=%h required 10 9999", state, count_bcd);
    end
    step(20);
    n_checks++;
    if (state !== 2'b10 || count_bcd !== 16'h9999 || digit_en !== 4'b0000) begin
      n_fail++;
      $display("FAIL pause_hold: state=%b count=%h en=%b required 10 9999 0000", state, count_bcd, digit_en);
    end
    send_cmd(2'b00, 16'h0000);
    n_checks++;
    if (state !== 2'b01 || count_bcd !== 16'h9999) begin
      n_fail++;
      $display("FAIL resume: state=%b count=%h required 01 9999", state, count_bcd);
    end
    step(1);
    n_checks++;
    if (count_bcd !== 16'h9998 || digit_en !== 4'b0001) begin
      n_fail++;
      $display("FAIL resume_phase: count=%h en=%b required 9998 0001", count_bcd, digit_en);
    end
  endtask

  task automatic test_err;
    send_cmd(2'b10, 16'h0000);
    dir = 1'b0;
    n_checks++;
    if (state !== 2'b00 || count_bcd !== 16'h0000 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear0: state=%b count=%h err=%b required 00 0000 0", state, count_bcd, err);
    end
    send_cmd(2'b11, 16'h00A3);
    n_checks++;
    if (err !== 1'b1 || count_bcd !== 16'h0000) begin
      n_fail++;
      $display("FAIL err_bad_load: err=%b count=%h required 1 0000", err, count_bcd);
    end
    send_cmd(2'b10, 16'h0000);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear1: err=%b required 0", err);
    end
    send_cmd(2'b11, 16'h0005);
    target = 16'h9000;
    send_cmd(2'b00, 16'h0000);
    // Load in RUN is accepted on the next tick edge: err sets, count still steps.
    send_cmd(2'b11, 16'h0777);
    n_checks++;
    if (err !== 1'b1 || count_bcd !== 16'h0006 || state !== 2'b01) begin
      n_fail++;
      $display("FAIL err_run_load: err=%b count=%h state=%b required 1 0006 01", err, count_bcd, state);
    end
    step(2);
    n_checks++;
    if (count_bcd !== 16'h0007 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: count=%h err=%b required 0007 1", count_bcd, err);
    end
    send_cmd(2'b10, 16'h0000);
    n_checks++;
    if (err !== 1'b0 || count_bcd !== 16'h0000 || state !== 2'b00) begin
      n_fail++;
      $display("FAIL err_clear2: err=%b count=%h state=%b required 0 0000 00", err, count_bcd, state);
    end
  endtask

  task automatic test_tick_collisions;
    target = 16'h0002;
    dir    = 1'b0;
    send_cmd(2'b00, 16'h0000);
    step(2);
    n_checks++;
    if (count_bcd !== 16'h0001) begin
      n_fail++;
      $display("FAIL coll_tick1: count=%h required 0001", count_bcd);
    end
    step(1);
    send_cmd(2'b01, 16'h0000);
    n_checks++;
    if (state !== 2'b11 || done !== 1'b1 || count_bcd !== 16'h0002) begin
      n_fail++;
      $display("FAIL stop_on_match: state=%b done=%b count=%h required 11 1 0002", state, done, count_bcd);
    end
    send_cmd(2'b00, 16'h0000);
    step(1);
    send_cmd(2'b10, 16'h0000);
    n_checks++;
    if (state !== 2'b00 || count_bcd !== 16'h0000 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_on_tick: state=%b count=%h done=%b required 00 0000 0", state, count_bcd, done);
    end
    step(2);
    n_checks++;
    if (state !== 2'b00 || count_bcd !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear_hold: state=%b count=%h required 00 0000", state, count_bcd);
    end
  endtask

  task automatic test_back_to_back;
    step(2);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_data  = 16'h0042;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready0: cmd_ready=%b required 1", cmd_ready);
    end
    step(1);
    n_checks++;
    if (cmd_ready !== 1'b0 || count_bcd !== 16'h0042) begin
      n_fail++;
      $display("FAIL b2b_first: ready=%b count=%h required 0 0042", cmd_ready, count_bcd);
    end
    cmd_data = 16'h0043;
    step(1);
    n_checks++;
    if (cmd_ready !== 1'b1 || count_bcd !== 16'h0042) begin
      n_fail++;
      $display("FAIL b2b_stall: ready=%b count=%h required 1 0042", cmd_ready, count_bcd);
    end
    step(1);
    n_checks++;
    if (cmd_ready !== 1'b0 || count_bcd !== 16'h0043) begin
      n_fail++;
      $display("FAIL b2b_second: ready=%b count=%h required 0 0043", cmd_ready, count_bcd);
    end
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 16'h0000;
  endtask

  task automatic test_reset_mid_run;
    target = 16'h0045;
    dir    = 1'b0;
    send_cmd(2'b00, 16'h0000);
    send_cmd(2'b11, 16'h0777);
    step(1);
    n_checks++;
    if (state !== 2'b01 || err !== 1'b1 || count_bcd !== 16'h0044) begin
      n_fail++;
      $display("FAIL pre_reset: state=%b err=%b count=%h required 01 1 0044", state, err, count_bcd);
    end
    #2;
    rst_asyn = 1'b0;
    #1;
    n_checks++;
    if (state !== 2'b00 || count_bcd !== 16'h0000 || digit_en !== 4'b0000 ||
        done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: state=%b count=%h en=%b done=%b err=%b ready=%b required 00 0000 0000 0 0 1",
               state, count_bcd, digit_en, done, err, cmd_ready);
    end
    #3;
    rst_asyn = 1'b1;
    step(4);
    n_checks++;
    if (state !== 2'b00 || count_bcd !== 16'h0000 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: state=%b count=%h done=%b required 00 0000 0", state, count_bcd, done);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 16'h0000;
    dir       = 1'b0;
    target    = 16'h0000;
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down_pause();
    test_err();
    test_tick_collisions();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_seq_ctrl.md
Name: bcd_seq_ctrl

Overview:
Sequencing controller for a cascaded multi-digit BCD counter chain built from our single-digit BCD counter. It owns the run/pause/clear/load state machine, the count-tick prescaler, the per-digit carry/borrow enables and terminal-value detection. Commands arrive over a valid/ready interface, and a done pulse is raised when the count reaches a programmed target. It sits between the front-panel/command logic and the digit display datapath.

Parameters:
DIGITS, 4, number of cascaded BCD digits (digit 0 = least significant).
PRESCALE, 10, clk cycles per count tick (>=1).

Ports:
clk  input  1  system clock, rising edge
rst_asyn  input  1  asynchronous reset, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  2  00 start, 01 stop, 10 clear, 11 load
cmd_data  input  4*DIGITS  BCD load value, used by load only
dir  input  1  0 count up, 1 count down; sampled on each tick
target  input  4*DIGITS  BCD terminal value
count_bcd  output  4*DIGITS  current count, one BCD nibble per digit
digit_en  output  DIGITS  one-cycle pulse per digit that changed on a tick
state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
done  output  1  one-cycle pulse on target match
err  output  1  sticky error flag

Behaviour:
- Reset (rst_asyn=0, async): state IDLE, count_bcd 0, prescaler 0, digit_en 0, done 0, err 0, cmd_ready 1.
- Handshake: a command is accepted on a cycle with cmd_valid&&cmd_ready. cmd_ready drops for exactly one cycle after each accept and is otherwise 1.
- Prescaler: runs only in RUN, counting 0..PRESCALE-1. A tick occurs on the cycle it equals PRESCALE-1, then it wraps to 0. It is held in PAUSE and cleared on entry from IDLE or DONE and on clear.
- Tick: count steps ±1 with BCD carry/borrow. Digit i changes only if all lower digits wrapped (9->0 up, 0->9 down). digit_en[i]=1 on the same edge the count updates, for each changed digit only.
- Wrap: up from all-9s gives all-0s; down from all-0s gives all-9s. No error on wrap.
- Target: if the post-tick count equals target, go to DONE and pulse done for 1 cycle, registered with the new count. Match is checked only on ticks, never on load or clear.
- FSM:
  - IDLE: start->RUN; load permitted; stop no-op.
  - RUN: stop->PAUSE; start no-op; load ignored and sets err.
  - PAUSE: start->RUN, resuming the prescaler phase; load permitted.
  - DONE: start->RUN, continuing from target, so the next match needs a full wrap; load permitted; stop no-op.
  - clear in any state: IDLE, count 0, prescaler 0, err 0.
- Load: if every cmd_data nibble is <=9, count_bcd=cmd_data the next cycle. Otherwise count is unchanged and err=1. err stays set until clear or reset.
- Tick and accepted command on the same cycle: the tick's count update is always applied. State priority is clear > target match > stop. Clear forces count 0. Stop with no match leaves the stepped count in PAUSE.
- dir changes take effect on the next tick only.
- cmd_op/cmd_data are ignored when not accepted.
- Reset mid-RUN aborts immediately; there is no pending done.

Test Plan:
- DIGITS=4, PRESCALE=2, target=0012, start, dir=0 -> count 0001 after 2 cycles, 0002 after 4, …; at 0012 state=DONE with done high 1 cycle; digit_en=0011 on the 0009->0010 tick.
- Load 9998, dir=0, target=0003, start -> 9999 then 0000 with digit_en=1111 on that tick, then 0001..0003, then DONE.
- Load 0001, dir=1, start -> 0000 then 9999 with digit_en=1111; stop -> PAUSE with count frozen across 20 cycles; start resumes with the prescaler phase kept.
- Load cmd_data=00A3 in IDLE -> err=1, count unchanged; load in RUN -> err=1, count keeps stepping; clear -> err=0, count 0000, IDLE.
- Stop accepted on the tick cycle that hits target -> DONE (not PAUSE) with done pulse. Clear on a tick cycle -> IDLE, count 0000.
- Back-to-back cmd_valid -> cmd_ready low 1 cycle after each accept, so the second command is taken one cycle later. rst_asyn low mid-RUN -> all outputs reset immediately without waiting for a clk edge.
